// File: rtl/ncl_sandbox_pkg.sv
// Shared constants and parameter sanity checks for the fork/join pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ncl_sandbox_pkg;

  // Join function selectors
  localparam int JOIN_CONCAT = 0;
  localparam int JOIN_XOR    = 1;

  // Legal parameter space for fork_join_pipe
  function automatic bit params_ok(input int width, input int branches,
                                   input int depth, input int mode);
    return (width >= 1) && (branches >= 2) && (branches <= 8) &&
           (depth >= 1) && ((mode == JOIN_CONCAT) || (mode == JOIN_XOR));
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data pipeline register with combinational upstream ready.
// Latency: 1 cycle from up_vld to dn_vld.
// Backpressure: up_rdy = empty or being drained this cycle, so a full chain streams 1/cycle.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             init,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_dat,
  output logic             up_rdy,
  output logic             dn_vld,
  output logic [WIDTH-1:0] dn_dat,
  input  logic             dn_rdy
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  assign up_rdy = !vld_q || dn_rdy;
  assign dn_vld = vld_q;
  assign dn_dat = dat_q;

  // Load when there is room (empty or content leaving); otherwise hold
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (up_rdy) begin
      vld_d = up_vld;
      if (up_vld) begin
        dat_d = up_dat;
      end
    end
  end

  // State register, cleared asynchronously by init
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/fork_join_pipe.sv
// Fork one token into BRANCHES pipes of DEPTH stages (branch i xors in i), join them into one output token.
// Latency: DEPTH+1 cycles from the accept cycle to out_valid, 1 token/cycle sustained.
// Backpressure: in_ready only when every branch head can load; a held branch or out_ready=0 stalls the fork.
module fork_join_pipe
  import ncl_sandbox_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BRANCHES = 2,
  parameter int DEPTH    = 3,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      init,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [BRANCHES-1:0]       branch_hold,
  output logic                      out_valid,
  output logic [WIDTH*BRANCHES-1:0] out_data,
  input  logic                      out_ready
);

  if (!params_ok(WIDTH, BRANCHES, DEPTH, MODE)) begin : g_param_check
    $error("fork_join_pipe: parameter out of range");
  end

  logic [BRANCHES-1:0]       st0_rdy;
  logic [BRANCHES-1:0]       last_vld;
  logic [BRANCHES-1:0]       present;
  logic [WIDTH*BRANCHES-1:0] last_dat;
  logic [WIDTH*BRANCHES-1:0] joined;
  logic                      accept;
  logic                      join_fire;

  logic                      out_vld_q, out_vld_d;
  logic [WIDTH*BRANCHES-1:0] out_dat_q, out_dat_d;

  // Fork is all-or-nothing: every branch head must be able to load
  assign in_ready  = (&st0_rdy) && !init;
  assign accept    = in_valid && in_ready;

  // A held branch keeps its tail token out of the join
  assign present   = last_vld & ~branch_hold;
  assign join_fire = (&present) && (!out_vld_q || out_ready);

  for (genvar i = 0; i < BRANCHES; i++) begin : g_br
    localparam logic [WIDTH-1:0] XK = WIDTH'(i);

    for (genvar j = 0; j < DEPTH; j++) begin : g_st
      logic             up_vld, up_rdy, dn_vld, dn_rdy;
      logic [WIDTH-1:0] up_dat, dn_dat;

      if (j == 0) begin : g_head
        assign up_vld = accept;
        assign up_dat = in_data ^ XK;
      end else begin : g_link
        assign up_vld = g_st[j-1].dn_vld;
        assign up_dat = g_st[j-1].dn_dat;
      end

      // The tail only pops when the whole join fires, so branches stay in lockstep
      if (j == DEPTH - 1) begin : g_tail
        assign dn_rdy = join_fire;
      end else begin : g_mid
        assign dn_rdy = g_st[j+1].up_rdy;
      end

      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk    (clk),
        .init   (init),
        .up_vld (up_vld),
        .up_dat (up_dat),
        .up_rdy (up_rdy),
        .dn_vld (dn_vld),
        .dn_dat (dn_dat),
        .dn_rdy (dn_rdy)
      );
    end

    assign st0_rdy[i]                 = g_st[0].up_rdy;
    assign last_vld[i]                = g_st[DEPTH-1].dn_vld;
    assign last_dat[i*WIDTH +: WIDTH] = g_st[DEPTH-1].dn_dat;
  end

  // Join function: concatenation keeps branch 0 in the LSBs, xor folds into the low word
  always_comb begin
    joined = '0;
    if (MODE == JOIN_XOR) begin
      for (int b = 0; b < BRANCHES; b++) begin
        joined[WIDTH-1:0] = joined[WIDTH-1:0] ^ last_dat[b*WIDTH +: WIDTH];
      end
    end else begin
      joined = last_dat;
    end
  end

  // Output register: load on join, empty on consume, otherwise hold
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (join_fire) begin
      out_vld_d = 1'b1;
      out_dat_d = joined;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  // Output state, cleared asynchronously by init
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;

endmodule

// File: tb/tb_fork_join_pipe.sv
// Scoreboarded bench for fork_join_pipe: default instance (2 branches, concat) and a 3-branch xor instance.
// Expected tokens are pushed at acceptance from a spec-level model; a negedge monitor pops on each output.
// Inputs change 1 time unit after the rising edge; all sampling happens on the falling edge.
module tb_fork_join_pipe;

  logic        clk = 1'b0;
  logic        init;
  always #5 clk = ~clk;

  // default instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [1:0]  branch_hold;
  logic [15:0] out_data;

  // 3-branch xor instance
  logic        x_in_valid, x_in_ready, x_out_valid, x_out_ready;
  logic [7:0]  x_in_data;
  logic [2:0]  x_hold;
  logic [23:0] x_out_data;

  fork_join_pipe u_dut (
    .clk         (clk),
    .init        (init),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .branch_hold (branch_hold),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  fork_join_pipe #(.WIDTH(8), .BRANCHES(3), .DEPTH(3), .MODE(1)) u_dut_x (
    .clk         (clk),
    .init        (init),
    .in_valid    (x_in_valid),
    .in_data     (x_in_data),
    .in_ready    (x_in_ready),
    .branch_hold (x_hold),
    .out_valid   (x_out_valid),
    .out_data    (x_out_data),
    .out_ready   (x_out_ready)
  );

  int          tot = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int          x_out_cyc[$];

  // Reference: branch b carries token^b; mode 0 concatenates (branch 0 low), mode 1 xors
  function automatic logic [31:0] model(input logic [7:0] t, input int nb, input int mode);
    logic [31:0] r;
    logic [7:0]  v;
    r = '0;
    for (int b = 0; b < nb; b++) begin
      v = t ^ 8'(b);
      if (mode == 0) r = r | (32'(v) << (8 * b));
      else           r[7:0] = r[7:0] ^ v;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (in_valid && in_ready)     q1.push_back(model(in_data, 2, 0));
    if (x_in_valid && x_in_ready) q2.push_back(model(x_in_data, 3, 1));
    if (out_valid && out_ready) begin
      if (q1.size() == 0) begin
        tot++; bad++;
        $display("FAIL dut_unexpected_output: got 0x%0h, expected no token", out_data);
      end else begin
        check("dut_out_data", {16'h0, out_data}, q1.pop_front());
      end
    end
    if (x_out_valid && x_out_ready) begin
      x_out_cyc.push_back(cyc);
      if (q2.size() == 0) begin
        tot++; bad++;
        $display("FAIL xdut_unexpected_output: got 0x%0h, expected no token", x_out_data);
      end else begin
        check("xdut_out_data", {8'h0, x_out_data}, q2.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle inputs, then wait (bounded) until both scoreboards and outputs are empty
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    in_valid = 1'b0; branch_hold = '0; out_ready = 1'b1;
    x_in_valid = 1'b0; x_hold = '0; x_out_ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (q1.size() == 0) && (q2.size() == 0) && !out_valid && !x_out_valid;
    end
    check(name, done, 1'b1);
    step();
  endtask

  // Single token on the default instance with exact latency check
  task automatic tok1(input logic [7:0] d, input logic [15:0] exp, input string name);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("%s_valid_c%0d", name, k), out_valid, (k == 4));
      if (k == 4) check({name, "_data"}, out_data, exp);
    end
    step();
  endtask

  task automatic tok2(input logic [7:0] d, input logic [23:0] exp, input string name);
    x_in_valid = 1'b1; x_in_data = d; x_out_ready = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, x_in_ready, 1'b1);
    step();
    x_in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("%s_valid_c%0d", name, k), x_out_valid, (k == 4));
      if (k == 4) check({name, "_data"}, x_out_data, exp);
    end
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", tot, bad + 1);
    $fatal(1);
  end

  initial begin
    int          acc;
    int          ti;
    logic [7:0]  tk[10];
    bit          seen;
    init = 1'b1;
    in_valid = 1'b1; in_data = 8'h55; branch_hold = '0; out_ready = 1'b1;
    x_in_valid = 1'b0; x_in_data = '0; x_hold = '0; x_out_ready = 1'b1;

    // Reset held with a token offered
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_x_out_valid", x_out_valid, 1'b0);
    end
    check("rst_out_data", out_data, 16'h0);
    step();
    init = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    step();
    drain("drain_after_reset");

    // Single token latency and concatenation
    tok1(8'hA5, 16'hA4A5, "single_a5");
    drain("drain_single");

    // Xor join, then a 16-token burst with no gaps
    tok2(8'h10, 24'h000013, "x_single_10");
    x_out_cyc.delete();
    for (int t = 0; t < 16; t++) begin
      x_in_valid = 1'b1; x_in_data = 8'(t);
      @(negedge clk);
      check($sformatf("x_burst_ready_%0d", t), x_in_ready, 1'b1);
      step();
    end
    x_in_valid = 1'b0;
    for (int k = 0; k < 20 && x_out_cyc.size() < 16; k++) step();
    check("x_burst_count", x_out_cyc.size(), 16);
    if (x_out_cyc.size() == 16) check("x_burst_span", x_out_cyc[15] - x_out_cyc[0], 15);
    drain("drain_burst");

    // Back-pressure: capacity DEPTH+1, then everything in order
    foreach (tk[k]) tk[k] = 8'($urandom);
    acc = 0; ti = 0; out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = tk[ti];
      @(negedge clk);
      if (in_ready) begin acc++; ti++; end
      step();
    end
    check("bp_accepted", acc, 4);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && ti < 10; k++) begin
      in_valid = 1'b1; in_data = tk[ti];
      @(negedge clk);
      if (in_ready) ti++;
      step();
    end
    in_valid = 1'b0;
    check("bp_all_accepted", ti, 10);
    drain("drain_bp");

    // Hold branch 0 while streaming
    acc = 0; branch_hold = 2'b01; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
      check($sformatf("hold_no_out_%0d", k), out_valid, 1'b0);
      if (in_ready) acc++;
      step();
    end
    @(negedge clk);
    check("hold_in_ready_low", in_ready, 1'b0);
    check("hold_accepted", acc, 3);
    step();
    branch_hold = 2'b00; in_valid = 1'b0;
    @(negedge clk);
    check("release_out_valid_c0", out_valid, 1'b0);
    @(negedge clk);
    check("release_out_valid_c1", out_valid, 1'b1);
    step();
    drain("drain_hold");

    // Mid-operation reset with a full pipe
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h70 + k);
      step();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("pre_rst_out_valid", seen, 1'b1);
    step();
    init = 1'b1;
    q1.delete(); q2.delete();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_data", out_data, 16'h0);
    step();
    init = 1'b0; out_ready = 1'b1;
    tok1(8'h3C, 16'h3D3C, "after_rst_3c");
    drain("drain_midrst");

    // Random traffic with random holds and back-pressure on both instances
    for (int k = 0; k < 1500; k++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 8'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      branch_hold = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      x_in_valid  = ($urandom_range(0, 3) != 0);
      x_in_data   = 8'($urandom);
      x_out_ready = ($urandom_range(0, 3) != 0);
      x_hold      = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 4) == 0)};
      step();
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
